// File: rtl/fp_cmp_writeback.sv
// Writeback stage for FP compare/min/max ops: turns the external comparator flags
// into a 64-bit result held in a one-deep output register, and tracks sticky NV and retire count.
module fp_cmp_writeback (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  op,
   input  logic        is_double_precision,
   input  logic [63:0] operand_a,
   input  logic [63:0] operand_b,
   input  logic        flag_lt,
   input  logic        flag_eq,
   input  logic        flag_gt,
   input  logic        flag_unordered,
   input  logic        flag_invalid,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] result,
   output logic        out_nv,
   output logic        fflag_nv,
   input  logic        clear_flags,
   output logic [15:0] retired_count
);

   typedef enum logic [2:0] {
      OP_FEQ  = 3'b000,
      OP_FLT  = 3'b001,
      OP_FLE  = 3'b010,
      OP_FMIN = 3'b011,
      OP_FMAX = 3'b100
   } op_e;

   localparam logic [63:0] CANON_NAN_DP = 64'h7FF8000000000000;
   localparam logic [63:0] CANON_NAN_SP = 64'h000000007FC00000;

   logic        out_valid_q, out_valid_d;
   logic [63:0] result_q, result_d;
   logic        out_nv_q, out_nv_d;
   logic        fflag_nv_q, fflag_nv_d;
   logic [15:0] retired_count_q, retired_count_d;

   logic        accept;
   logic        consume;

   logic [63:0] a_sel, b_sel;
   logic        a_sign, b_sign;
   logic        a_nan, b_nan;
   logic [63:0] canon_nan;
   logic        is_min;
   logic [63:0] minmax_res;
   logic [63:0] op_res;
   logic        op_nv;

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;
   assign consume  = out_valid_q && out_ready;

   // SP operands live in the low word; the upper word is ignored and zeroed in results.
   always_comb begin
      a_sel     = operand_a;
      b_sel     = operand_b;
      a_sign    = operand_a[63];
      b_sign    = operand_b[63];
      a_nan     = (&operand_a[62:52]) && (|operand_a[51:0]);
      b_nan     = (&operand_b[62:52]) && (|operand_b[51:0]);
      canon_nan = CANON_NAN_DP;
      if (!is_double_precision) begin
         a_sel     = {32'b0, operand_a[31:0]};
         b_sel     = {32'b0, operand_b[31:0]};
         a_sign    = operand_a[31];
         b_sign    = operand_b[31];
         a_nan     = (&operand_a[30:23]) && (|operand_a[22:0]);
         b_nan     = (&operand_b[30:23]) && (|operand_b[22:0]);
         canon_nan = CANON_NAN_SP;
      end
   end

   // Equal operands can still differ in sign (+0/-0): min prefers negative, max positive.
   always_comb begin
      is_min     = (op == OP_FMIN);
      minmax_res = a_sel;
      if (a_nan && b_nan) begin
         minmax_res = canon_nan;
      end else if (a_nan) begin
         minmax_res = b_sel;
      end else if (b_nan) begin
         minmax_res = a_sel;
      end else if (flag_lt) begin
         minmax_res = is_min ? a_sel : b_sel;
      end else if (flag_gt) begin
         minmax_res = is_min ? b_sel : a_sel;
      end else if (is_min) begin
         minmax_res = (!a_sign && b_sign) ? b_sel : a_sel;
      end else begin
         minmax_res = (a_sign && !b_sign) ? b_sel : a_sel;
      end
   end

   always_comb begin
      op_res = 64'b0;
      op_nv  = 1'b0;
      case (op_e'(op))
         OP_FEQ: begin
            op_res = {63'b0, flag_eq};
            op_nv  = flag_invalid;
         end
         OP_FLT: begin
            op_res = {63'b0, flag_lt};
            op_nv  = flag_unordered;
         end
         OP_FLE: begin
            op_res = {63'b0, flag_lt | flag_eq};
            op_nv  = flag_unordered;
         end
         OP_FMIN, OP_FMAX: begin
            op_res = minmax_res;
            op_nv  = flag_invalid;
         end
         default: begin
            op_res = 64'b0;
            op_nv  = 1'b0;
         end
      endcase
   end

   // A new accept overwrites the register; otherwise a consumed result drains it.
   always_comb begin
      out_valid_d     = out_valid_q;
      result_d        = result_q;
      out_nv_d        = out_nv_q;
      fflag_nv_d      = fflag_nv_q;
      retired_count_d = retired_count_q;
      if (accept) begin
         out_valid_d = 1'b1;
         result_d    = op_res;
         out_nv_d    = op_nv;
      end else if (consume) begin
         out_valid_d = 1'b0;
      end
      if (consume) begin
         retired_count_d = retired_count_q + 16'd1;
      end
      if (consume && out_nv_q) begin
         fflag_nv_d = 1'b1;
      end else if (clear_flags) begin
         fflag_nv_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q     <= 1'b0;
         result_q        <= 64'b0;
         out_nv_q        <= 1'b0;
         fflag_nv_q      <= 1'b0;
         retired_count_q <= 16'b0;
      end else begin
         out_valid_q     <= out_valid_d;
         result_q        <= result_d;
         out_nv_q        <= out_nv_d;
         fflag_nv_q      <= fflag_nv_d;
         retired_count_q <= retired_count_d;
      end
   end

   assign out_valid     = out_valid_q;
   assign result        = result_q;
   assign out_nv        = out_nv_q;
   assign fflag_nv      = fflag_nv_q;
   assign retired_count = retired_count_q;

endmodule

// File: doc/fp_cmp_writeback.md
FP_CMP_WRITEBACK -- requirements
Module: fp_cmp_writeback

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port in_valid  input  1  upstream holds a valid compare op.
REQ-004 SHALL have port in_ready  output  1  stage accepts an op this cycle.
REQ-005 SHALL have port op  input  3  000 FEQ, 001 FLT, 010 FLE, 011 FMIN, 100 FMAX, 101-111 illegal.
REQ-006 SHALL have port is_double_precision  input  1  1 = DP, 0 = SP (operand in bits [31:0]).
REQ-007 SHALL have ports operand_a, operand_b  input  64  raw IEEE-754 operands.
REQ-008 SHALL have ports flag_lt, flag_eq, flag_gt, flag_unordered, flag_invalid  input  1 each  combinational compare result for the same operands.
REQ-009 SHALL have port out_valid  output  1  result register holds a valid result.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-011 SHALL have port result  output  64  registered result.
REQ-012 SHALL have port out_nv  output  1  registered invalid-operation flag for the held result.
REQ-013 SHALL have port fflag_nv  output  1  sticky accumulated NV.
REQ-014 SHALL have port clear_flags  input  1  synchronous clear of fflag_nv.
REQ-015 SHALL have port retired_count  output  16  count of results consumed downstream.

Function
REQ-016 Accept SHALL be in_valid && in_ready; in_ready SHALL equal !out_valid || out_ready (combinational, one-deep pipeline register).
REQ-017 Latency SHALL be 1 cycle: an op accepted in cycle N SHALL appear with out_valid=1 in cycle N+1.
REQ-018 Back-to-back accepts SHALL sustain one op per cycle while out_ready=1.
REQ-019 While out_valid && !out_ready, result, out_nv and out_valid SHALL hold unchanged.
REQ-020 When out_valid && out_ready and no accept, out_valid SHALL clear next cycle.
REQ-021 FEQ: result = {63'b0, flag_eq}; out_nv = flag_invalid.
REQ-022 FLT: result = {63'b0, flag_lt}; out_nv = flag_unordered.
REQ-023 FLE: result = {63'b0, flag_lt | flag_eq}; out_nv = flag_unordered.
REQ-024 NaN detect for FMIN/FMAX SHALL use exponent all-ones and nonzero fraction at the selected precision.
REQ-025 FMIN/FMAX, both NaN: result = canonical NaN (DP 64'h7FF8000000000000; SP 64'h000000007FC00000).
REQ-026 FMIN/FMAX, exactly one NaN: result = the non-NaN operand.
REQ-027 FMIN, no NaN: lt -> a; gt -> b; eq -> operand with sign bit set (a if both same sign). FMAX mirrored: gt -> a; lt -> b; eq -> operand with sign clear.
REQ-028 Sign bit SHALL be bit 63 (DP) or bit 31 (SP); SP results SHALL zero upper 32 bits.
REQ-029 FMIN/FMAX: out_nv = flag_invalid.
REQ-030 Illegal op: result 0, out_nv 0, still handshaked normally.
REQ-031 fflag_nv SHALL set on cycle after out_valid && out_ready && out_nv; clear_flags clears it; simultaneous set and clear: set wins.
REQ-032 retired_count SHALL increment on each out_valid && out_ready, wrapping 16'hFFFF -> 0.

Reset
REQ-033 rst SHALL immediately force out_valid=0, result=0, out_nv=0, fflag_nv=0, retired_count=0, independent of clk.
REQ-034 An op held in the result register when rst asserts SHALL be discarded, not counted.
REQ-035 in_ready SHALL be 1 during and after reset (out_valid=0).

Verification
REQ-036 FLT DP, a=1.0 (3FF0...), b=2.0 (4000...), flag_lt=1, out_ready=1 -> next cycle out_valid=1, result=1, out_nv=0, retired_count=1 one cycle later.
REQ-037 FMIN SP, a=32'h80000000, b=32'h00000000, flag_eq=1 -> result=64'h0000000080000000; FMAX same -> 64'h0.
REQ-038 FMAX DP, a=sNaN 7FF0000000000001, b=3.0, flag_invalid=1 -> result=b, out_nv=1, fflag_nv=1 after consumption; clear_flags pulse -> 0.
REQ-039 Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, result stable; out_ready=1 -> next op loads same cycle, count +1.
REQ-040 Async reset mid-stall with out_valid=1 -> out_valid=0 immediately, retired_count=0; retired_count preload-by-traffic to FFFF then one more consume -> 0.
